// File: rtl/data_mem_responder.sv
// Purpose : single-outstanding data-memory responder for a pipeline MEM stage (word array, read/write, tag echo).
// Latency : response strobe WAIT_CYCLES+1 rising edges after the accept edge (accept edge counted); accepts spaced WAIT_CYCLES+2.
// Backpr. : Out_Ready high only in IDLE; In_Valid while busy is ignored, never queued.
//
// Ports: Clk/Rst_n (async active-low); In_Valid, In_MEMControl {MemRead,MemWrite}, In_Address (byte),
//        In_Data, In_WBControl (tag) -> Out_Ready, Out_RespValid, Out_ReadData, Out_WBControl, Out_Error, Out_Busy.
// Build option: define DMEM_ERR_CHECK_EN to flag misaligned / out-of-range / 00-11 control requests via Out_Error.
//               Without it Out_Error is constant 0, low address bits are ignored and the index wraps.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        In_Valid,
    input  logic [1:0]  In_MEMControl,
    input  logic [31:0] In_Address,
    input  logic [31:0] In_Data,
    input  logic [1:0]  In_WBControl,
    output logic        Out_Ready,
    output logic        Out_RespValid,
    output logic [31:0] Out_ReadData,
    output logic [1:0]  Out_WBControl,
    output logic        Out_Error,
    output logic        Out_Busy
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    // Request captured at accept
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [1:0]  ctrl_q;
    logic [1:0]  tag_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic [31:0] eff_addr;
    logic [31:0] eff_data;
    logic [1:0]  eff_ctrl;
    logic [1:0]  eff_tag;
    logic [AW-1:0] idx;
    logic        is_write;
    logic        is_read;
    logic        req_err;
    logic        do_write;
    logic [31:0] resp_data;

    assign accept = In_Valid && Out_Ready;

    // With WAIT_CYCLES=0 the response is formed on the accept edge itself, so
    // the request fields come straight from the inputs while still in IDLE.
    always_comb begin
        eff_addr = addr_q;
        eff_data = data_q;
        eff_ctrl = ctrl_q;
        eff_tag  = tag_q;
        if (state == IDLE) begin
            eff_addr = In_Address;
            eff_data = In_Data;
            eff_ctrl = In_MEMControl;
            eff_tag  = In_WBControl;
        end
    end

    always_comb begin
        enter_resp = 1'b0;
        if (state == IDLE && accept && WAIT_CYCLES == 0)
            enter_resp = 1'b1;
        else if (state == WAIT && cnt == 4'd1)
            enter_resp = 1'b1;
    end

    assign idx      = eff_addr[AW+1:2];
    assign is_write = (eff_ctrl == 2'b01);
    assign is_read  = (eff_ctrl == 2'b10);

`ifdef DMEM_ERR_CHECK_EN
    // Misaligned, beyond the array, or not exactly one of read/write.
    assign req_err = (eff_addr[1:0] != 2'b00)
                  || (eff_addr[31:AW+2] != '0)
                  || !(is_write || is_read);
`else
    assign req_err = 1'b0;
`endif

    assign do_write  = enter_resp && is_write && !req_err;
    assign resp_data = (is_read && !req_err) ? mem[idx] : 32'd0;

    // Control FSM with registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            addr_q        <= 32'd0;
            data_q        <= 32'd0;
            ctrl_q        <= 2'd0;
            tag_q         <= 2'd0;
            Out_Ready     <= 1'b0;
            Out_RespValid <= 1'b0;
            Out_ReadData  <= 32'd0;
            Out_WBControl <= 2'd0;
            Out_Error     <= 1'b0;
            Out_Busy      <= 1'b0;
        end else begin
            // Response fields are non-zero only during the single RESP cycle.
            Out_RespValid <= 1'b0;
            Out_ReadData  <= 32'd0;
            Out_WBControl <= 2'd0;
            Out_Error     <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q    <= In_Address;
                        data_q    <= In_Data;
                        ctrl_q    <= In_MEMControl;
                        tag_q     <= In_WBControl;
                        Out_Ready <= 1'b0;
                        Out_Busy  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end else begin
                        // Also raises Ready on the first edge after reset release.
                        Out_Ready <= 1'b1;
                        Out_Busy  <= 1'b0;
                    end
                end
                WAIT: begin
                    Out_Ready <= 1'b0;
                    Out_Busy  <= 1'b1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    Out_Ready <= 1'b1;
                    Out_Busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= 4'd0;
                    Out_Ready <= 1'b0;
                    Out_Busy  <= 1'b0;
                end
            endcase

            if (enter_resp) begin
                Out_RespValid <= 1'b1;
                Out_ReadData  <= resp_data;
                Out_WBControl <= eff_tag;
                Out_Error     <= req_err;
            end
        end
    end

    // Data array: cleared by reset; written only on the edge entering RESP, so a
    // reset during WAIT drops the pending write.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= 32'd0;
        end else if (do_write) begin
            mem[idx] <= eff_data;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

`ifdef DMEM_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;

    // main instance (defaults)
    logic        In_Valid = 1'b0;
    logic [1:0]  In_MEMControl = 2'd0;
    logic [31:0] In_Address = 32'd0;
    logic [31:0] In_Data = 32'd0;
    logic [1:0]  In_WBControl = 2'd0;
    logic        Out_Ready, Out_RespValid, Out_Error, Out_Busy;
    logic [31:0] Out_ReadData;
    logic [1:0]  Out_WBControl;

    // zero-wait instance
    logic        v0 = 1'b0;
    logic [1:0]  c0 = 2'd0;
    logic [31:0] a0 = 32'd0;
    logic [31:0] d0 = 32'd0;
    logic [1:0]  t0 = 2'd0;
    logic        r0_rdy, r0_vld, r0_err, r0_busy;
    logic [31:0] r0_dat;
    logic [1:0]  r0_tag;

    data_mem_responder u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_MEMControl(In_MEMControl),
        .In_Address(In_Address), .In_Data(In_Data), .In_WBControl(In_WBControl),
        .Out_Ready(Out_Ready), .Out_RespValid(Out_RespValid), .Out_ReadData(Out_ReadData),
        .Out_WBControl(Out_WBControl), .Out_Error(Out_Error), .Out_Busy(Out_Busy)
    );

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .In_Valid(v0), .In_MEMControl(c0),
        .In_Address(a0), .In_Data(d0), .In_WBControl(t0),
        .Out_Ready(r0_rdy), .Out_RespValid(r0_vld), .Out_ReadData(r0_dat),
        .Out_WBControl(r0_tag), .Out_Error(r0_err), .Out_Busy(r0_busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] rd;
        logic [1:0]  tag;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sbq[$];
    bit   sb_off = 1'b0;

    // Scoreboard side: responses popped and compared; between responses the
    // response fields must read zero.
    always @(negedge Clk) begin
        if (Rst_n && !sb_off) begin
            if (Out_RespValid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("resp_data", Out_ReadData, e.rd);
                    chk("resp_tag", Out_WBControl, e.tag);
                    chk("resp_err", Out_Error, e.err);
                    chk("resp_latency_cycle", cyc, e.cyc);
                end
            end else begin
                chk("idle_fields_zero", {Out_ReadData, Out_WBControl, Out_Error}, 0);
            end
        end
    end

    // Called at a negedge. Response expected after the accept edge plus W more edges.
    task automatic issue(input logic [1:0] ctrl, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] tag, input logic [31:0] exp_rd, input logic exp_err);
        int waited = 0;
        exp_t e;
        while (!Out_Ready && waited < 50) begin
            @(negedge Clk);
            waited++;
        end
        if (!Out_Ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        In_MEMControl = ctrl;
        In_Address    = addr;
        In_Data       = data;
        In_WBControl  = tag;
        In_Valid      = 1'b1;
        e.rd  = exp_rd;
        e.tag = tag;
        e.err = exp_err;
        e.cyc = cyc + 1 + W;
        sbq.push_back(e);
        @(posedge Clk);
        #1 In_Valid = 1'b0;
        @(negedge Clk);
    endtask

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  tag;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_resp;
        int last;
        int first;

        vecs[0]  = '{2'b10, 32'd0,   32'd0,          2'b01, 32'd0, 1'b0};
        vecs[1]  = '{2'b01, 32'd8,   32'd8,          2'b10, 32'd0, 1'b0};
        vecs[2]  = '{2'b10, 32'd8,   32'd0,          2'b10, 32'd8, 1'b0};
        vecs[3]  = '{2'b01, 32'd0,   32'hA5A5_0000,  2'b00, 32'd0, 1'b0};
        vecs[4]  = '{2'b01, 32'd4,   32'h1234_5678,  2'b11, 32'd0, 1'b0};
        vecs[5]  = '{2'b10, 32'd4,   32'd0,          2'b00, 32'h1234_5678, 1'b0};
        vecs[6]  = '{2'b00, 32'd8,   32'h0000_FFFF,  2'b01, 32'd0, ERR_EN};
        vecs[7]  = '{2'b11, 32'd8,   32'h0000_FFFF,  2'b11, 32'd0, ERR_EN};
        vecs[8]  = '{2'b10, 32'd8,   32'd0,          2'b01, 32'd8, 1'b0};
        vecs[9]  = '{2'b10, 32'd2,   32'd0,          2'b10, ERR_EN ? 32'd0 : 32'hA5A5_0000, ERR_EN};
        vecs[10] = '{2'b01, 32'd256, 32'h0BAD_F00D,  2'b01, 32'd0, ERR_EN};
        vecs[11] = '{2'b10, 32'd0,   32'd0,          2'b10, ERR_EN ? 32'hA5A5_0000 : 32'h0BAD_F00D, 1'b0};
        vecs[12] = '{2'b01, 32'd252, 32'h0000_7777,  2'b11, 32'd0, 1'b0};
        vecs[13] = '{2'b10, 32'd252, 32'd0,          2'b11, 32'h0000_7777, 1'b0};

        // Reset: everything low while held, Ready one edge after release.
        repeat (3) @(negedge Clk);
        chk("reset_outputs", {Out_Ready, Out_RespValid, Out_ReadData, Out_WBControl, Out_Error, Out_Busy}, 0);
        chk("reset_outputs_w0", {r0_rdy, r0_vld, r0_dat, r0_tag, r0_err, r0_busy}, 0);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("ready_after_release", Out_Ready, 1);
        chk("busy_after_release", Out_Busy, 0);

        for (int i = 0; i < 14; i++)
            issue(vecs[i].ctrl, vecs[i].addr, vecs[i].data, vecs[i].tag, vecs[i].exp_rd, vecs[i].exp_err);
        repeat (W + 3) @(negedge Clk);
        chk("table_drained", sbq.size(), 0);

        // In_Valid held high: one accept per W+2 cycles, Busy mirrors not-Ready.
        while (!Out_Ready) @(negedge Clk);
        sb_off = 1'b1;
        In_MEMControl = 2'b10;
        In_Address    = 32'd8;
        In_WBControl  = 2'b01;
        In_Valid      = 1'b1;
        cnt_resp = 0;
        last = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            chk("busy_vs_ready", Out_Busy, !Out_Ready);
            if (Out_RespValid) begin
                cnt_resp++;
                chk("held_resp_data", Out_ReadData, 32'd8);
                if (last >= 0) chk("held_accept_spacing", cyc - last, W + 2);
                last = cyc;
            end
        end
        In_Valid = 1'b0;
        chk("held_resp_count", cnt_resp, 4);
        @(negedge Clk);
        sb_off = 1'b0;

        // Reset pulsed during WAIT of a write: outputs clear at once, write lost.
        issue(2'b01, 32'd12, 32'hDEAD_BEEF, 2'b10, 32'd0, 1'b0);
        chk("in_wait_busy", Out_Busy, 1);
        Rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {Out_Ready, Out_RespValid, Out_ReadData, Out_WBControl, Out_Error, Out_Busy}, 0);
        sbq.delete();
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        issue(2'b10, 32'd12, 32'd0, 2'b01, 32'd0, 1'b0);
        issue(2'b10, 32'd8, 32'd0, 2'b11, 32'd0, 1'b0);
        repeat (W + 3) @(negedge Clk);
        chk("reset_seq_drained", sbq.size(), 0);

        // Zero wait states: response on the accept edge, accepts every 2 cycles.
        while (!r0_rdy) @(negedge Clk);
        c0 = 2'b01; a0 = 32'd4; d0 = 32'h55; t0 = 2'b01; v0 = 1'b1;
        first = cyc + 1;
        cnt_resp = 0;
        last = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (r0_vld) begin
                cnt_resp++;
                if (last < 0) chk("w0_first_latency", cyc, first);
                else chk("w0_accept_spacing", cyc - last, 2);
                last = cyc;
            end
        end
        v0 = 1'b0;
        chk("w0_resp_count", cnt_resp, 4);
        @(negedge Clk);
        chk("w0_ready_idle", r0_rdy, 1);
        c0 = 2'b10; a0 = 32'd4; t0 = 2'b10; v0 = 1'b1;
        @(posedge Clk);
        #1 v0 = 1'b0;
        @(negedge Clk);
        chk("w0_read_vld", r0_vld, 1);
        chk("w0_read_data", r0_dat, 32'h55);
        chk("w0_read_tag", r0_tag, 2'b10);
        @(negedge Clk);
        chk("w0_vld_one_cycle", r0_vld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, meaning the number of 32-bit words in the data array; the value SHALL be a power of two, 2..1024.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted between accept and response; legal range 0..15.
REQ-003 Port Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port Rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port In_Valid, input, 1 bit: MEM stage presents a request.
REQ-006 Port In_MEMControl, input, 2 bits: request type; bit1 = MemRead, bit0 = MemWrite.
REQ-007 Port In_Address, input, 32 bits: byte address.
REQ-008 Port In_Data, input, 32 bits: write data.
REQ-009 Port In_WBControl, input, 2 bits: sideband tag, returned unchanged with the response.
REQ-010 Port Out_Ready, output, 1 bit: responder can accept a request this cycle.
REQ-011 Port Out_RespValid, output, 1 bit: one-cycle response strobe.
REQ-012 Port Out_ReadData, output, 32 bits: read result.
REQ-013 Port Out_WBControl, output, 2 bits: tag captured at accept.
REQ-014 Port Out_Error, output, 1 bit: request was rejected.
REQ-015 Port Out_Busy, output, 1 bit: FSM is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, WAIT and RESP.
REQ-017 Out_Ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on the rising edge where In_Valid=1 and Out_Ready=1.
REQ-019 At accept, the block SHALL register Address, Data, MEMControl and WBControl.
REQ-020 From IDLE, the FSM SHALL go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-021 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter, and then go to RESP.
REQ-022 RESP SHALL last exactly one cycle with Out_RespValid=1 and then return to IDLE.
REQ-023 Response latency SHALL be exactly WAIT_CYCLES+1 rising edges from the accept edge to Out_RespValid high.
REQ-024 Minimum spacing between accepts SHALL be WAIT_CYCLES+2 cycles.
REQ-025 In_Valid while not IDLE SHALL be ignored; the request is not queued.
REQ-026 The word index SHALL be Address[log2(DEPTH_WORDS)+1:2].
REQ-027 Control 01 (write): array[index] SHALL be written on the edge entering RESP; Out_ReadData SHALL be 0.
REQ-028 Control 10 (read): Out_ReadData SHALL equal array[index] as sampled when entering RESP.
REQ-029 Control 00 or 11: no array change, Out_ReadData=0, and Out_Error per REQ-036.
REQ-030 Out_ReadData, Out_WBControl and Out_Error SHALL be valid only while Out_RespValid=1 and SHALL be 0 otherwise.
REQ-031 Out_Busy SHALL be 1 in WAIT and RESP.

Reset
REQ-032 Asserting Rst_n=0 SHALL immediately force IDLE, counter=0, and all outputs to 0, including Out_Ready.
REQ-033 Every array word SHALL reset to 0.
REQ-034 Out_Ready SHALL be 1 in the first cycle after Rst_n rises.
REQ-035 Reset in mid-operation SHALL discard the pending request; a write not yet in RESP SHALL never reach the array.

Configuration
REQ-036 With macro DMEM_ERR_CHECK_EN defined, Out_Error SHALL be 1 in RESP for any of: Address[1:0]!=0, Address>=4*DEPTH_WORDS, or control 00/11; an erroring request SHALL leave the array unchanged and give Out_ReadData=0.
REQ-037 Without DMEM_ERR_CHECK_EN, Out_Error SHALL be constant 0, Address[1:0] SHALL be ignored, upper address bits SHALL be dropped (index wraps modulo DEPTH_WORDS), and control 00/11 SHALL be a silent no-op response.

Verification
REQ-038 Reset, then release -> all outputs 0 during reset; Out_Ready=1 in the first cycle after release; read of address 0 returns 0.
REQ-039 Defaults: write addr 8, data 8, ctrl 01, tag 10; then read addr 8, ctrl 10 -> each Out_RespValid exactly 3 edges after accept; read returns ReadData=8 and WBControl echoed.
REQ-040 Error checks: read addr 2 -> with macro, Error=1 and ReadData=0; without macro, returns word 0. Write addr 256 -> with macro, Error=1 and array unchanged; without macro, word 0 overwritten.
REQ-041 In_Valid held high through WAIT -> exactly one accept per WAIT_CYCLES+2 cycles; Out_Busy high for WAIT and RESP.
REQ-042 Write addr 12 data 0xDEADBEEF, Rst_n pulsed low during WAIT -> outputs clear at once; a later read of addr 12 returns 0.
REQ-043 WAIT_CYCLES=0 -> Out_RespValid 1 edge after accept; back-to-back accepts every 2 cycles.
